// File: rtl/sdram_memtest_master.sv
// Avalon-MM SDRAM memory tester: writes an address-XOR-seed pattern to num_words
// words, reads them back with up to MAX_PENDING pipelined reads, and reports mismatches.
module sdram_memtest_master #(
  parameter int ADDR_W      = 25,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [15:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int CW = ADDR_W + 1;
  localparam int OW = $clog2(MAX_PENDING + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     num_q, num_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, chk_cnt_q, chk_cnt_d;
  logic [15:0]       seed_q, seed_d, wdata_q, wdata_d, err_q, err_d;
  logic [OW-1:0]     out_q, out_d;
  logic [ADDR_W-1:0] addr_q, addr_d, first_q, first_d;
  logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              wr_acc, rd_acc, rdv_ok;
  logic [CW-1:0]     wr_inc, rd_inc;

  function automatic logic [15:0] pattern_f(input logic [15:0] addr_lo, input logic [15:0] sd);
    return addr_lo ^ sd;
  endfunction

  assign wr_acc = wr_q && !avm_waitrequest;
  assign rd_acc = rd_q && !avm_waitrequest;
  assign wr_inc = wr_cnt_q + CW'(1);
  assign rd_inc = rd_cnt_q + CW'(1);
  // Read data only counts while a read is actually outstanding, so stray beats are dropped.
  assign rdv_ok = avm_readdatavalid && (state_q == S_READ || state_q == S_DRAIN) &&
                  (out_q != {OW{1'b0}}) && (chk_cnt_q < num_q);

  // Next-state and next-output computation for the whole test sequence.
  always_comb begin
    state_d = state_q;  num_d = num_q;  seed_d = seed_q;
    wr_cnt_d = wr_cnt_q;  rd_cnt_d = rd_cnt_q;  chk_cnt_d = chk_cnt_q;
    addr_d = addr_q;  rd_d = rd_q;  wr_d = wr_q;  wdata_d = wdata_q;
    busy_d = busy_q;  done_d = 1'b0;  pass_d = pass_q;  err_d = err_q;  first_d = first_q;

    case ({rd_acc, rdv_ok})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    if (rdv_ok) begin
      chk_cnt_d = chk_cnt_q + CW'(1);
      if (avm_readdata != pattern_f(chk_cnt_q[15:0], seed_q)) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        else                   err_d = err_q;
        if (err_q == 16'h0000) first_d = chk_cnt_q[ADDR_W-1:0];
        else                   first_d = first_q;
      end else begin
        err_d = err_q;
      end
    end else begin
      chk_cnt_d = chk_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d   = seed;
          num_d    = {1'b0, num_words};
          wr_cnt_d = {CW{1'b0}};
          rd_cnt_d = {CW{1'b0}};
          chk_cnt_d = {CW{1'b0}};
          out_d    = {OW{1'b0}};
          addr_d   = {ADDR_W{1'b0}};
          err_d    = 16'h0000;
          first_d  = {ADDR_W{1'b0}};
          busy_d   = 1'b1;
          if (num_words == {ADDR_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            wdata_d = seed;
            pass_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          wr_cnt_d = wr_inc;
          if (wr_inc == num_q) begin
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            addr_d  = {ADDR_W{1'b0}};
            state_d = S_READ;
          end else begin
            addr_d  = wr_inc[ADDR_W-1:0];
            wdata_d = pattern_f(wr_inc[15:0], seed_q);
          end
        end else begin
          wr_d = 1'b1;
        end
      end
      S_READ: begin
        if (rd_acc) begin
          rd_cnt_d = rd_inc;
          if (rd_inc == num_q) begin
            rd_d    = 1'b0;
            state_d = S_DRAIN;
          end else begin
            addr_d = rd_inc[ADDR_W-1:0];
            rd_d   = (out_d < OW'(MAX_PENDING));
          end
        end else begin
          rd_d = (out_d < OW'(MAX_PENDING));
        end
      end
      S_DRAIN: begin
        // Pass uses err_d so a mismatch on the last beat is reflected.
        if (out_d == {OW{1'b0}}) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'h0000);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;  num_q <= {CW{1'b0}};  seed_q <= 16'h0000;
      wr_cnt_q <= {CW{1'b0}};  rd_cnt_q <= {CW{1'b0}};  chk_cnt_q <= {CW{1'b0}};
      out_q <= {OW{1'b0}};  addr_q <= {ADDR_W{1'b0}};  rd_q <= 1'b0;  wr_q <= 1'b0;
      wdata_q <= 16'h0000;  busy_q <= 1'b0;  done_q <= 1'b0;  pass_q <= 1'b0;
      err_q <= 16'h0000;  first_q <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;  num_q <= num_d;  seed_q <= seed_d;
      wr_cnt_q <= wr_cnt_d;  rd_cnt_q <= rd_cnt_d;  chk_cnt_q <= chk_cnt_d;
      out_q <= out_d;  addr_q <= addr_d;  rd_q <= rd_d;  wr_q <= wr_d;
      wdata_q <= wdata_d;  busy_q <= busy_d;  done_q <= done_d;  pass_q <= pass_d;
      err_q <= err_d;  first_q <= first_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 2'b11;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_sdram_memtest_master.sv
// Directed bench for sdram_memtest_master with a behavioural Avalon-MM memory slave.
module tb_sdram_memtest_master;
  localparam int AW = 25;

  logic          clk_clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] num_words = 25'd0;
  logic [15:0]   seed = 16'h0000;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [15:0]   avm_writedata;
  logic [1:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [15:0]   avm_readdata = 16'h0000;
  logic          avm_readdatavalid = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_err_addr;

  sdram_memtest_master #(.ADDR_W(AW), .MAX_PENDING(4)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
    .num_words(num_words), .seed(seed), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail = 0;

  // Slave model state and bus monitors
  logic [15:0] mem [0:15];
  int q_addr[$];
  int q_due[$];
  int cyc = 0, wr_acc_n = 0, rd_acc_n = 0, model_out = 0, over_n = 0, full_n = 0;
  int mon_err = 0, bus_cyc = 0, done_cnt = 0;
  logic stall_en = 1'b0, corrupt_en = 1'b0;
  int lat = 1;
  int corrupt_addr = 5;
  logic prev_wst = 1'b0, prev_rst = 1'b0;
  logic [AW-1:0] prev_addr = 25'd0;
  logic [15:0] prev_data = 16'h0000;

  always @(posedge clk_clk) begin
    cyc <= cyc + 1;
    if (avm_write && !avm_waitrequest) begin
      mem[avm_address[3:0]] <= avm_writedata;
      wr_acc_n <= wr_acc_n + 1;
    end
    if (avm_read && !avm_waitrequest) begin
      q_addr.push_back(int'(avm_address));
      q_due.push_back(cyc + lat);
      rd_acc_n <= rd_acc_n + 1;
    end
    model_out <= model_out + ((avm_read && !avm_waitrequest) ? 1 : 0) - (avm_readdatavalid ? 1 : 0);
    if (model_out > 4) over_n <= over_n + 1;
    if (model_out == 4) full_n <= full_n + 1;
    if (avm_read || avm_write) bus_cyc <= bus_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    mon_err <= mon_err
             + ((!reset_reset && prev_wst && !(avm_write && avm_address == prev_addr && avm_writedata == prev_data)) ? 1 : 0)
             + ((!reset_reset && prev_rst && !(avm_read && avm_address == prev_addr)) ? 1 : 0)
             + ((avm_read && avm_write) ? 1 : 0);
    prev_wst  <= avm_write && avm_waitrequest && !reset_reset;
    prev_rst  <= avm_read && avm_waitrequest && !reset_reset;
    prev_addr <= avm_address;
    prev_data <= avm_writedata;
  end

  always @(negedge clk_clk) begin
    avm_waitrequest <= stall_en ? ($urandom_range(1, 0) == 32'd1) : 1'b0;
    if (q_due.size() > 0 && cyc >= q_due[0]) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata <= mem[q_addr[0][3:0]] ^ ((corrupt_en && q_addr[0] == corrupt_addr) ? 16'h0001 : 16'h0000);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      avm_readdatavalid <= 1'b0;
      avm_readdata <= 16'h0000;
    end
  end

  task automatic run_test(input logic [AW-1:0] nw, input logic [15:0] sd, input int glitch_at, output int cycles);
    @(negedge clk_clk);
    num_words = nw; seed = sd; start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 3000) begin
      if (cycles == glitch_at) begin start = 1'b1; num_words = 25'd3; end
      else start = 1'b0;
      @(negedge clk_clk);
      cycles++;
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL run_done: done=%b after %0d cycles, expected 1", done, cycles); end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    n_checks++;
    if ({avm_read, avm_write, busy, done, pass} !== 5'b00000) begin n_fail++;
      $display("FAIL reset_flags: rd/wr/busy/done/pass=%b, expected 00000", {avm_read, avm_write, busy, done, pass}); end
    n_checks++;
    if (avm_address !== 25'd0 || avm_writedata !== 16'h0000) begin n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h, expected 0/0", avm_address, avm_writedata); end
    n_checks++;
    if (error_count !== 16'h0000 || first_err_addr !== 25'd0) begin n_fail++;
      $display("FAIL reset_err: err=%h first=%h, expected 0/0", error_count, first_err_addr); end
    n_checks++;
    if (avm_byteenable !== 2'b11) begin n_fail++; $display("FAIL byteenable: %b, expected 11", avm_byteenable); end
    reset_reset = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic test_basic();
    int c; int bw; int br; int bm;
    lat = 1; bw = wr_acc_n; br = rd_acc_n; bm = mon_err;
    run_test(25'd8, 16'hA5A5, 0, c);
    n_checks++;
    if (pass !== 1'b1 || error_count !== 16'h0000 || first_err_addr !== 25'd0) begin n_fail++;
      $display("FAIL basic_result: pass=%b err=%h first=%h, expected 1/0/0", pass, error_count, first_err_addr); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: busy=%b in DONE, expected 1", busy); end
    @(negedge clk_clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL basic_pulse: done=%b busy=%b after DONE, expected 0/0", done, busy); end
    n_checks++;
    if (wr_acc_n - bw != 8 || rd_acc_n - br != 8) begin n_fail++;
      $display("FAIL basic_counts: writes=%0d reads=%0d, expected 8/8", wr_acc_n - bw, rd_acc_n - br); end
    n_checks++;
    if (mem[3] !== 16'hA5A6 || mem[7] !== 16'hA5A2) begin n_fail++;
      $display("FAIL basic_pattern: mem3=%h mem7=%h, expected A5A6/A5A2", mem[3], mem[7]); end
    n_checks++;
    if (mon_err != bm) begin n_fail++; $display("FAIL basic_bus: %0d protocol errors, expected 0", mon_err - bm); end
  endtask

  task automatic test_stall();
    int c; int bw; int br; int bm;
    lat = 2; stall_en = 1'b1; bw = wr_acc_n; br = rd_acc_n; bm = mon_err;
    run_test(25'd8, 16'h1234, 0, c);
    @(negedge clk_clk);
    stall_en = 1'b0;
    n_checks++;
    if (wr_acc_n - bw != 8 || rd_acc_n - br != 8) begin n_fail++;
      $display("FAIL stall_counts: writes=%0d reads=%0d, expected 8/8", wr_acc_n - bw, rd_acc_n - br); end
    n_checks++;
    if (mon_err != bm) begin n_fail++; $display("FAIL stall_stable: %0d stall/overlap errors, expected 0", mon_err - bm); end
    n_checks++;
    if (pass !== 1'b1 || error_count !== 16'h0000) begin n_fail++;
      $display("FAIL stall_result: pass=%b err=%h, expected 1/0", pass, error_count); end
  endtask

  task automatic test_corrupt();
    int c;
    lat = 3; corrupt_en = 1'b1;
    run_test(25'd8, 16'h0F0F, 0, c);
    n_checks++;
    if (pass !== 1'b0 || error_count !== 16'h0001 || first_err_addr !== 25'd5) begin n_fail++;
      $display("FAIL corrupt_result: pass=%b err=%h first=%h, expected 0/0001/5", pass, error_count, first_err_addr); end
    @(negedge clk_clk);
    corrupt_en = 1'b0;
  endtask

  task automatic test_zero_and_busy_start();
    int c; int bw; int br; int bb; int bd;
    lat = 1; bw = wr_acc_n; br = rd_acc_n; bb = bus_cyc;
    run_test(25'd0, 16'h1111, 0, c);
    n_checks++;
    if (c != 1) begin n_fail++; $display("FAIL zero_latency: done after %0d cycles, expected 1", c); end
    n_checks++;
    if (pass !== 1'b1 || error_count !== 16'h0000 || first_err_addr !== 25'd0) begin n_fail++;
      $display("FAIL zero_result: pass=%b err=%h first=%h, expected 1/0/0", pass, error_count, first_err_addr); end
    @(negedge clk_clk);
    n_checks++;
    if (bus_cyc != bb || wr_acc_n != bw || rd_acc_n != br || done !== 1'b0) begin n_fail++;
      $display("FAIL zero_bus: bus cycles=%0d done=%b, expected 0/0", bus_cyc - bb, done); end
    bw = wr_acc_n; br = rd_acc_n; bd = done_cnt;
    run_test(25'd8, 16'h3C3C, 5, c);
    @(negedge clk_clk);
    n_checks++;
    if (wr_acc_n - bw != 8 || rd_acc_n - br != 8 || pass !== 1'b1) begin n_fail++;
      $display("FAIL busy_start: writes=%0d reads=%0d pass=%b, expected 8/8/1", wr_acc_n - bw, rd_acc_n - br, pass); end
    n_checks++;
    if (done_cnt - bd != 1) begin n_fail++; $display("FAIL busy_done_count: %0d done cycles, expected 1", done_cnt - bd); end
  endtask

  task automatic test_latency();
    int c; int bo; int bf;
    lat = 10; bo = over_n; bf = full_n;
    run_test(25'd8, 16'hFFFF, 0, c);
    n_checks++;
    if (over_n != bo) begin n_fail++; $display("FAIL lat_max_pending: %0d cycles above 4 outstanding, expected 0", over_n - bo); end
    n_checks++;
    if (full_n == bf) begin n_fail++; $display("FAIL lat_fill: outstanding never reached 4, expected to reach 4"); end
    n_checks++;
    if (pass !== 1'b1 || error_count !== 16'h0000) begin n_fail++;
      $display("FAIL lat_result: pass=%b err=%h, expected 1/0", pass, error_count); end
  endtask

  task automatic test_reset_mid();
    int k; int bd;
    lat = 10;
    @(negedge clk_clk);
    num_words = 25'd8; seed = 16'h5A5A; start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    k = 0;
    while (model_out != 2 && k < 200) begin @(negedge clk_clk); k++; end
    n_checks++;
    if (model_out != 2) begin n_fail++; $display("FAIL mid_wait: outstanding=%0d, expected 2", model_out); end
    bd = done_cnt;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    n_checks++;
    if ({avm_read, avm_write, busy, done, pass} !== 5'b00000 || avm_address !== 25'd0 || avm_writedata !== 16'h0000) begin n_fail++;
      $display("FAIL mid_reset_out: rd/wr/busy/done/pass=%b addr=%h data=%h, expected 0", {avm_read, avm_write, busy, done, pass}, avm_address, avm_writedata); end
    reset_reset = 1'b0;
    repeat (30) @(negedge clk_clk);
    n_checks++;
    if (error_count !== 16'h0000 || first_err_addr !== 25'd0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL mid_late_rdv: err=%h first=%h busy=%b, expected 0/0/0", error_count, first_err_addr, busy); end
    n_checks++;
    if (done_cnt != bd || q_due.size() != 0) begin n_fail++;
      $display("FAIL mid_no_done: done cycles=%0d pending=%0d, expected 0/0", done_cnt - bd, q_due.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_zero_and_busy_start();
    test_latency();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_memtest_master.md
SDRAM_MEMTEST_MASTER -- requirements
Module: sdram_memtest_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning word-address width (32M x16 SDRAM).
REQ-002 SHALL have parameter MAX_PENDING, default 4, meaning maximum outstanding reads (power of two, 1..8).
REQ-003 SHALL have port clk_clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle test request.
REQ-006 SHALL have port num_words  input  ADDR_W  words to test, sampled at accepted start.
REQ-007 SHALL have port seed  input  16  pattern seed, sampled at accepted start.
REQ-008 SHALL have port avm_address  output  ADDR_W  Avalon-MM word address.
REQ-009 SHALL have port avm_read  output  1  Avalon read request.
REQ-010 SHALL have port avm_write  output  1  Avalon write request.
REQ-011 SHALL have port avm_writedata  output  16  write data.
REQ-012 SHALL have port avm_byteenable  output  2  constant 2'b11.
REQ-013 SHALL have port avm_waitrequest  input  1  slave stall.
REQ-014 SHALL have port avm_readdata  input  16  read data.
REQ-015 SHALL have port avm_readdatavalid  input  1  read data qualifier (pipelined reads).
REQ-016 SHALL have port busy  output  1  test in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port pass  output  1  result of last test; valid from done onward.
REQ-019 SHALL have port error_count  output  16  mismatches in last test, saturating at 16'hFFFF.
REQ-020 SHALL have port first_err_addr  output  ADDR_W  address of first mismatch; 0 if none.

Function
REQ-021 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-023 On accepted start with num_words=0 SHALL go IDLE->DONE directly, pass=1, error_count=0.
REQ-024 On accepted start with num_words>0 SHALL clear error_count/first_err_addr, set pass=0, enter WRITE next cycle.
REQ-025 Pattern for address A SHALL be A[15:0] XOR seed (sampled).
REQ-026 WRITE: avm_write=1, avm_address=wr counter (from 0), writedata=pattern; all held stable while avm_waitrequest=1; counter advances only on cycle with avm_write=1 and avm_waitrequest=0.
REQ-027 After write of address num_words-1 accepted, SHALL deassert avm_write and enter READ next cycle.
REQ-028 READ: avm_read=1 with address from rd-issue counter (from 0) whenever outstanding < MAX_PENDING, else avm_read=0; address held while waitrequest=1.
REQ-029 Outstanding counter SHALL +1 on accepted read, -1 on readdatavalid, unchanged when both occur same cycle.
REQ-030 Each readdatavalid SHALL compare avm_readdata to pattern of rd-check counter (in-order), then increment check counter.
REQ-031 On mismatch SHALL increment error_count (saturating); on first mismatch record check address in first_err_addr.
REQ-032 After read of num_words-1 accepted SHALL enter DRAIN; DRAIN->DONE when outstanding=0 and no readdatavalid pending.
REQ-033 DONE SHALL last one cycle: done=1, pass=(error_count==0, including a mismatch on the final cycle), then IDLE.
REQ-034 busy SHALL be 1 in WRITE, READ, DRAIN, DONE; 0 in IDLE.
REQ-035 avm_read and avm_write SHALL never be asserted together.
REQ-036 readdatavalid in IDLE SHALL be ignored.
REQ-037 Counters SHALL be ADDR_W+1 wide so num_words = 2^ADDR_W-1 does not wrap.

Reset
REQ-038 reset_reset=1 SHALL force next cycle: IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0, pass=0, error_count=0, first_err_addr=0, all counters 0.
REQ-039 Reset mid-transfer SHALL abort the test, no done pulse; late readdatavalid after reset ignored.

Verification
REQ-040 num_words=8, seed=16'hA5A5, zero-wait ideal memory -> 8 writes then 8 reads, done pulse, pass=1, error_count=0.
REQ-041 Same, waitrequest random 50% -> address/data stable during stalls, exactly 8 writes and 8 reads, pass=1.
REQ-042 Memory corrupts address 5 (bit 0 flipped), read latency 3 -> pass=0, error_count=1, first_err_addr=5.
REQ-043 Readdatavalid delayed 10 cycles, MAX_PENDING=4 -> never more than 4 reads outstanding, pass=1.
REQ-044 num_words=0 -> done one cycle after start, pass=1, no bus activity; start during busy ignored.
REQ-045 Reset asserted in READ with 2 outstanding -> all outputs to reset values next cycle, later readdatavalid ignored, error_count stays 0.
